// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared FSM states, size codes and region nibbles for the memory bus arbiter.
package mem_bus_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;
    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;
    localparam int SZ_UNSIGNED = 2;
    localparam logic [3:0] REG_ROM = 4'h0;
    localparam logic [3:0] REG_RAM = 4'h1;
    localparam logic [3:0] REG_KB = 4'h2;
    localparam logic [3:0] REG_DISP = 4'h3;
endpackage

// File: rtl/mem_bus_arbiter_arb_pick2.sv
// arb_pick2: two-way one-hot grant; ARB_ROUND_ROBIN_EN selects round-robin ties, else port 0 wins.
module arb_pick2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);
`ifdef ARB_ROUND_ROBIN_EN
    assign grant = (&req) ? (last_grant ? 2'b01 : 2'b10) : req;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant = req[0] ? 2'b01 : req;
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: registers one master's request and runs a single access on the mem_* bus.
// Tie-break policy set by ARB_ROUND_ROBIN_EN inside arb_pick2.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int LAT_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_size,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_size,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_u_b_h_w,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    state_t state, state_nxt;
    logic [1:0] req, grant;
    logic [LAT_W-1:0] cnt;
    logic [31:0] rdata_q;
    logic we_q, sel_q, last_grant, done;

    assign req = {m1_req, m0_req};

    arb_pick2 u_pick (.req(req), .last_grant(last_grant), .grant(grant));

    always_comb begin
        done = we_q || cnt == LAT_W'(READ_LAT);
        state_nxt = (state == IDLE) ? ((|req) ? ACCESS : IDLE) :
                    (state == ACCESS) ? (done ? ACK : ACCESS) : IDLE;
        mem_read = state == ACCESS && !we_q;
        mem_write = state == ACCESS && we_q;
        m0_ack = state == ACK && !sel_q;
        m1_ack = state == ACK && sel_q;
        m0_rdata = (m0_ack && !we_q) ? rdata_q : 32'h0;
        m1_rdata = (m1_ack && !we_q) ? rdata_q : 32'h0;
        busy = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            we_q <= 1'b0;
            sel_q <= 1'b0;
            last_grant <= 1'b1;
            rdata_q <= 32'h0;
            mem_addr <= 32'h0;
            mem_wdata <= 32'h0;
            mem_u_b_h_w <= 3'b000;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |req) begin
                sel_q <= grant[1];
                last_grant <= grant[1];
                we_q <= grant[1] ? m1_we : m0_we;
                mem_addr <= grant[1] ? m1_addr : m0_addr;
                mem_wdata <= grant[1] ? m1_wdata : m0_wdata;
                mem_u_b_h_w <= grant[1] ? m1_size : m0_size;
                cnt <= '0;
            end
            if (state == ACCESS)
                cnt <= cnt + LAT_W'(1);
            // read data is valid on the final strobe cycle, READ_LAT after the address
            if (state == ACCESS && !we_q && done)
                rdata_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench with random masters, a latency-modelled RAM and an arbitration model.
module tb_mem_bus_arbiter;
    localparam int READ_LAT = 1;
    localparam int LAT_W = 3;
    localparam int TMO = 3000;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [2:0]  size;
    } txn_t;

    logic clk = 1'b0, rst = 1'b1;
    logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [2:0] m0_size = 0, m1_size = 0;
    logic m0_ack, m1_ack, mem_read, mem_write, busy;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0] mem_u_b_h_w;

    int tests = 0, fails = 0;
    txn_t q0[$], q1[$];
    int grant_log[$];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.READ_LAT(READ_LAT), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_u_b_h_w(mem_u_b_h_w),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return ((a ^ 32'h1000_0004) * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    // RAM model: data for the strobed address appears READ_LAT cycles later
    logic [31:0] pipe [READ_LAT];
    always @(posedge clk) begin
        pipe[0] <= mem_read ? data_of(mem_addr) : 32'h0;
        for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[READ_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input int p, input bit we, input logic [31:0] a, input logic [31:0] w, input logic [2:0] s);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = w; t.size = s; t.rdata = we ? 32'h0 : data_of(a);
        if (p == 0) begin
            q0.push_back(t); m0_we = we; m0_addr = a; m0_wdata = w; m0_size = s; m0_req = 1;
        end else begin
            q1.push_back(t); m1_we = we; m1_addr = a; m1_wdata = w; m1_size = s; m1_req = 1;
        end
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (p == 0 ? m0_ack : m1_ack) break;
            if (i == TMO) begin
                chk(p == 0 ? "m0_ack_timeout" : "m1_ack_timeout", 0, 1);
                break;
            end
        end
        if (p == 0) m0_req = 0; else m1_req = 0;
    endtask

    // Monitor: arbitration, bus contents, strobe lengths and acks, all from observed outputs
    logic [1:0] samp_req;
    logic samp_rst;
    always @(posedge clk) begin
        samp_req <= {m1_req, m0_req};
        samp_rst <= rst;
    end

    bit prev_strobe = 0, prev_quiet = 0, last = 1, cur = 0, cur_we = 0;
    int run = 0;
    always @(negedge clk) begin
        logic strobe;
        int win;
        txn_t t;
        strobe = mem_read | mem_write;
        if (samp_rst) begin
            prev_strobe = 0; prev_quiet = 0; last = 1; run = 0;
        end else begin
            chk("busy", {31'h0, busy}, {31'h0, strobe | m0_ack | m1_ack});
            if (prev_quiet) chk("grant_latency", {31'h0, strobe}, {31'h0, samp_req != 2'b00});
            if (m0_ack && m1_ack) chk("both_acks", 1, 0);
            if (m0_ack) begin
                if (q0.size() == 0) chk("m0_unexpected_ack", 1, 0);
                else begin t = q0.pop_front(); chk("m0_rdata", m0_rdata, t.rdata); end
            end
            if (m1_ack) begin
                if (q1.size() == 0) chk("m1_unexpected_ack", 1, 0);
                else begin t = q1.pop_front(); chk("m1_rdata", m1_rdata, t.rdata); end
            end
            if (strobe && !prev_strobe) begin
                win = (samp_req == 2'b11) ? (RR ? int'(!last) : 0) : (samp_req == 2'b10) ? 1 : 0;
                last = win[0]; cur = win[0]; run = 1;
                grant_log.push_back(win);
                if ((win == 0 ? q0.size() : q1.size()) == 0) chk("grant_no_txn", win, 99);
                else begin
                    t = (win == 0) ? q0[0] : q1[0];
                    cur_we = t.we;
                    chk("mem_write_sel", {31'h0, mem_write}, {31'h0, t.we});
                    chk("mem_addr", mem_addr, t.addr);
                    chk("mem_size", {29'h0, mem_u_b_h_w}, {29'h0, t.size});
                    if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
                end
            end else if (strobe) begin
                run++;
                chk("strobe_kind", {31'h0, mem_write}, {31'h0, cur_we});
            end else if (prev_strobe) begin
                chk("strobe_len", run, cur_we ? 1 : READ_LAT + 1);
                chk("ack_after_access", {31'h0, cur ? m1_ack : m0_ack}, 1);
            end
            prev_strobe = strobe;
            prev_quiet = !strobe && !m0_ack && !m1_ack;
        end
    end

    task automatic master(input int p, input int n);
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = $urandom;
            a[31:28] = 4'($urandom_range(0, 3));
            do_txn(p, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        int exp_g[3];
        txn_t t;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_mem_read", {31'h0, mem_read}, 0);
        chk("rst_mem_write", {31'h0, mem_write}, 0);
        chk("rst_m0_ack", {31'h0, m0_ack}, 0);
        chk("rst_m1_ack", {31'h0, m1_ack}, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_size", {29'h0, mem_u_b_h_w}, 0);
        rst = 0;
        // tie right after reset: m0 requests twice back to back, m1 once
        fork
            begin
                do_txn(0, 0, 32'h1000_0100, 0, 3'b010);
                do_txn(0, 1, 32'h1000_0104, 32'h1234_5678, 3'b010);
            end
            do_txn(1, 1, 32'h3000_0000, 32'h55, 3'b000);
        join
        exp_g = RR ? '{0, 1, 0} : '{0, 0, 1};
        chk("tie_grant_count", grant_log.size(), 3);
        for (int i = 0; i < 3 && i < grant_log.size(); i++) chk("tie_grant_order", grant_log[i], exp_g[i]);
        do_txn(0, 0, 32'h1000_0004, 0, 3'b010);
        do_txn(1, 1, 32'h3000_0010, 32'h0000_00AB, 3'b000);
        // m1 retargets its address while waiting behind m0
        fork
            do_txn(0, 0, 32'h1000_0020, 0, 3'b010);
            begin
                @(negedge clk);
                m1_we = 0; m1_size = 3'b010; m1_addr = 32'h1000_0000; m1_req = 1;
                @(negedge clk);
                do_txn(1, 0, 32'h1000_0008, 0, 3'b010);
            end
        join
        fork
            master(0, 30);
            master(1, 30);
        join
        // reset in the second strobe cycle of a read aborts it
        t.we = 0; t.addr = 32'h1000_0040; t.wdata = 0; t.size = 3'b010; t.rdata = data_of(t.addr);
        q0.push_back(t);
        m0_we = 0; m0_addr = t.addr; m0_size = t.size; m0_req = 1;
        for (int i = 0; i <= TMO; i++) begin
            @(negedge clk);
            if (mem_read) break;
            if (i == TMO) chk("abort_read_timeout", 0, 1);
        end
        @(negedge clk);
        rst = 1; m0_req = 0;
        @(negedge clk);
        chk("abort_mem_read", {31'h0, mem_read}, 0);
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_m0_ack", {31'h0, m0_ack}, 0);
        rst = 0;
        q0.delete();
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_ack", {31'h0, m0_ack}, 0);
        end
        do_txn(0, 0, 32'h1000_0040, 0, 3'b010);
        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
